// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor (a - b), truncation rounding.
// Shared 25-bit add/sub datapath with a one-bit-per-cycle normaliser.
module fp_sub_seq #(
  parameter int N        = 32,
  parameter int NORM_MAX = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         out_overflow,
  output logic         out_invalid,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  state_t r_state;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [24:0]  r_ml;
  logic [24:0]  r_ms;
  logic [24:0]  r_m;
  logic         r_sl;
  logic         r_ss;
  logic         r_sign;
  logic [9:0]   r_exp;
  logic [4:0]   r_cnt;
  logic         r_spec;
  logic         r_sinv;
  logic [N-1:0] r_sdiff;

  logic         w_sa;
  logic         w_sb;
  logic [7:0]   w_ea;
  logic [7:0]   w_eb;
  logic [22:0]  w_fa;
  logic [22:0]  w_fb;
  logic         w_nan_a;
  logic         w_nan_b;
  logic         w_inf_a;
  logic         w_inf_b;
  logic         w_nan;
  logic         w_spec;
  logic [N-1:0] w_sdiff;
  logic [24:0]  w_xa;
  logic [24:0]  w_xb;
  logic [7:0]   w_ea1;
  logic [7:0]   w_eb1;
  logic         w_a_big;
  logic [7:0]   w_el;
  logic [7:0]   w_es;
  logic [24:0]  w_xl;
  logic [24:0]  w_xs;
  logic         w_sl;
  logic         w_ss;
  logic [7:0]   w_dexp;
  logic [24:0]  w_xs_sh;
  logic [24:0]  w_sum;

  // Subtraction is an add with b's sign flipped
  assign w_sa = r_a[31];
  assign w_sb = ~r_b[31];
  assign w_ea = r_a[30:23];
  assign w_eb = r_b[30:23];
  assign w_fa = r_a[22:0];
  assign w_fb = r_b[22:0];

  assign w_nan_a = (&w_ea) & (|w_fa);
  assign w_nan_b = (&w_eb) & (|w_fb);
  assign w_inf_a = (&w_ea) & ~(|w_fa);
  assign w_inf_b = (&w_eb) & ~(|w_fb);

  assign w_nan  = w_nan_a | w_nan_b |
                  (w_inf_a & w_inf_b & (w_sa != w_sb));
  assign w_spec = w_nan_a | w_nan_b | w_inf_a | w_inf_b;

  always_comb begin
    w_sdiff = {w_sb, 8'hFF, 23'd0};
    if (w_nan)
      w_sdiff = 32'h7F80_0001;
    else if (w_inf_a)
      w_sdiff = {w_sa, 8'hFF, 23'd0};
  end

  assign w_xa  = {1'b0, |w_ea, w_fa};
  assign w_xb  = {1'b0, |w_eb, w_fb};
  assign w_ea1 = (w_ea == 8'd0) ? 8'd1 : w_ea;
  assign w_eb1 = (w_eb == 8'd0) ? 8'd1 : w_eb;

  assign w_a_big = (r_a[30:0] >= r_b[30:0]);
  assign w_el    = w_a_big ? w_ea1 : w_eb1;
  assign w_es    = w_a_big ? w_eb1 : w_ea1;
  assign w_xl    = w_a_big ? w_xa  : w_xb;
  assign w_xs    = w_a_big ? w_xb  : w_xa;
  assign w_sl    = w_a_big ? w_sa  : w_sb;
  assign w_ss    = w_a_big ? w_sb  : w_sa;

  assign w_dexp  = w_el - w_es;
  assign w_xs_sh = (w_dexp >= 8'd25) ? 25'd0 : (w_xs >> w_dexp);

  assign w_sum = (r_sl == r_ss) ? (r_ml + r_ms) : (r_ml - r_ms);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      diff         <= '0;
      out_overflow <= 1'b0;
      out_invalid  <= 1'b0;
      busy         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ml         <= '0;
      r_ms         <= '0;
      r_m          <= '0;
      r_sl         <= 1'b0;
      r_ss         <= 1'b0;
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_cnt        <= '0;
      r_spec       <= 1'b0;
      r_sinv       <= 1'b0;
      r_sdiff      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_spec  <= w_spec;
          r_sinv  <= w_nan;
          r_sdiff <= w_sdiff;
          r_ml    <= w_xl;
          r_ms    <= w_xs_sh;
          r_sl    <= w_sl;
          r_ss    <= w_ss;
          r_exp   <= {2'b00, w_el};
          r_cnt   <= '0;
          r_state <= w_spec ? S_PACK : S_ADD;
        end
        S_ADD: begin
          r_m     <= w_sum;
          r_sign  <= r_sl;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_m[24]) begin
            r_m     <= r_m >> 1;
            r_exp   <= r_exp + 10'd1;
            r_state <= S_PACK;
          end else if (r_m == 25'd0) begin
            r_sign  <= 1'b0;
            r_state <= S_PACK;
          end else if (r_m[23] || r_exp == 10'd1 ||
                       r_cnt >= 5'(NORM_MAX - 1)) begin
            r_state <= S_PACK;
          end else begin
            r_m   <= r_m << 1;
            r_exp <= r_exp - 10'd1;
          end
        end
        S_PACK: begin
          out_overflow <= 1'b0;
          out_invalid  <= 1'b0;
          if (r_spec) begin
            diff        <= r_sdiff;
            out_invalid <= r_sinv;
          end else if (r_exp >= 10'd255) begin
            diff         <= {r_sign, 8'hFF, 23'd0};
            out_overflow <= 1'b1;
          end else begin
            // Without the hidden bit the value is a denormal
            diff <= {r_sign,
                     r_m[23] ? r_exp[7:0] : 8'd0,
                     r_m[22:0]};
          end
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_overflow <= 1'b0;
            out_invalid  <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: arithmetic reference model plus pinned vectors.
// One negedge process compares every meaningful cycle.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        out_overflow;
  logic        out_invalid;
  logic        busy;

  fp_sub_seq #(.N(32), .NORM_MAX(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .diff         (diff),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seen = 0;
  int   meas = 0;

  logic [31:0] last_d;
  logic        last_ovf;
  logic        last_inv;
  int          last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Value-level reference: align with truncation, add, renormalise
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    logic sa, sb, sl, ss, s;
    int ea, eb, ma, mb, xa, xb, xl, xs, el, es, d, m, e, sh;
    r.d = 32'h0; r.ovf = 1'b0; r.inv = 1'b0; r.lat = 2;
    sa = x[31]; sb = ~y[31];
    ea = int'(x[30:23]); eb = int'(y[30:23]);
    ma = int'(x[22:0]);  mb = int'(y[22:0]);
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) begin
      r.d = 32'h7F800001; r.inv = 1'b1;
      return r;
    end
    if (ea == 255) begin r.d = {sa, 8'hFF, 23'd0}; return r; end
    if (eb == 255) begin r.d = {sb, 8'hFF, 23'd0}; return r; end
    xa = (ea != 0 ? (1 << 23) : 0) + ma;
    xb = (eb != 0 ? (1 << 23) : 0) + mb;
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    if (x[30:0] >= y[30:0]) begin
      xl = xa; xs = xb; el = ea; es = eb; sl = sa; ss = sb;
    end else begin
      xl = xb; xs = xa; el = eb; es = ea; sl = sb; ss = sa;
    end
    d  = el - es;
    xs = (d >= 25) ? 0 : (xs >> d);
    m  = (sl == ss) ? xl + xs : xl - xs;
    s  = sl; e = el; sh = 0;
    if (m >= (1 << 24)) begin
      m = m >> 1; e = e + 1;
    end else if (m == 0) begin
      s = 1'b0;
    end else begin
      while (m < (1 << 23) && e > 1) begin
        m = m << 1; e = e - 1; sh++;
      end
    end
    r.lat = 4 + sh;
    if (e >= 255) begin
      r.d = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
    end else begin
      r.d = {s, (m >= (1 << 23)) ? e[7:0] : 8'h00, m[22:0]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_q.delete();
      seen = 0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (seen == 0) begin
            seen = 1;
            meas = cyc - acc_q[0];
            chk("latency", meas, q[0].lat);
          end
          chk("diff", diff, q[0].d);
          chk("overflow", {31'd0, out_overflow}, {31'd0, q[0].ovf});
          chk("invalid", {31'd0, out_invalid}, {31'd0, q[0].inv});
          if (out_ready) begin
            last_d   = diff;
            last_ovf = out_overflow;
            last_inv = out_invalid;
            last_lat = meas;
            void'(q.pop_front());
            void'(acc_q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    int ok;
    ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok == 0) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!out_valid && q.size() == 0) return;
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [31:0] xa, input logic [31:0] xb);
    last_d = 32'hDEADBEEF; last_lat = -1;
    last_ovf = 1'bx; last_inv = 1'bx;
    send(xa, xb);
    wait_done();
  endtask

  task automatic pin(input string nm, input logic [31:0] d,
                     input logic ovf, input logic inv, input int lat);
    chk({nm, "_diff"}, last_d, d);
    chk({nm, "_ovf"}, {31'd0, last_ovf}, {31'd0, ovf});
    chk({nm, "_inv"}, {31'd0, last_inv}, {31'd0, inv});
    chk({nm, "_lat"}, last_lat, lat);
  endtask

  initial begin
    int ok;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {30'd0, out_overflow, out_invalid}, 32'd0);

    run(32'h40400000, 32'h3F800000); pin("3m1", 32'h40000000, 0, 0, 4);
    run(32'h3F800000, 32'h3F400000); pin("1m075", 32'h3E800000, 0, 0, 6);
    run(32'h3F800000, 32'h3F800000); pin("xmx", 32'h00000000, 0, 0, 4);
    run(32'h7F800000, 32'h7F800000); pin("infminf", 32'h7F800001, 0, 1, 2);
    run(32'h7F7FFFFF, 32'hFF7FFFFF); pin("ovf", 32'h7F800000, 1, 0, 4);
    run(32'h00000001, 32'h80000001); pin("denorm", 32'h00000002, 0, 0, 4);
    run(32'h3F800000, 32'h40400000); pin("1m3", 32'hC0000000, 0, 0, 4);
    run(32'h00800000, 32'h00000001); pin("minnorm", 32'h007FFFFF, 0, 0, 4);
    run(32'hC1200000, 32'h41200000); pin("m10m10", 32'hC1A00000, 0, 0, 4);
    run(32'h3F800001, 32'h3F800000); pin("ulp", 32'h34000000, 0, 0, 27);
    run(32'hFF800000, 32'h7F800000); pin("ninf", 32'hFF800000, 0, 0, 2);
    run(32'h7FC00000, 32'h3F800000); pin("nan", 32'h7F800001, 0, 1, 2);
    run(32'h3F800000, 32'h0D800000); pin("far", 32'h3F800000, 0, 0, 4);
    run(32'h3F800000, 32'hFF800000);
    run(32'h40A00000, 32'h3F000000);
    run(32'h80000000, 32'h00000000);

    // backpressure: result held, inputs ignored
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (out_valid) begin ok = 1; break; end
    end
    if (ok == 0) chk("bp_valid_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      chk("bp_diff", diff, 32'h40000000);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_xfer_in_ready", {31'd0, in_ready}, 32'd1);
    wait_done();

    // reset while normalising
    send(32'h3F800000, 32'h3F400000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    run(32'h40400000, 32'h3F800000); pin("post_rst", 32'h40000000, 0, 0, 4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_sub_seq.md
Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor: result = a − b.
- Sits beside the combinational floating-point adder in the arithmetic path. It reuses the same field decode, special-case encodings and truncation rounding.
- Trades area for latency: one shared 25-bit magnitude add/subtract, and an iterative one-bit-per-cycle normaliser.
- valid/ready handshake on both input and output.

Parameters:
- N, 32, operand/result width; only 32 (1/8/23 split) is supported.
- NORM_MAX, 24, maximum left-normalise iterations before forcing PACK (safety bound).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, IEEE-754 single.
- b  input  N  subtrahend, IEEE-754 single.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  N  a − b, IEEE-754 single.
- out_overflow  output  1  result overflowed to infinity.
- out_invalid  output  1  result is NaN.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM → IDLE.
  - in_ready=1, out_valid=0, diff=0, out_overflow=0, out_invalid=0, busy=0.
  - Reset asserted mid-operation abandons the operation; no partial result is ever presented.
- Handshake:
  - Input transfer when in_valid && in_ready. in_ready=1 only in IDLE.
  - Output transfer when out_valid && out_ready. diff and the flags hold stable while out_valid=1 && out_ready=0.
- Decode:
  - Hidden bit = (exp != 0). Exponent 0 is treated as 1 for alignment, so denormals are handled correctly.
  - b's sign is inverted, then the operation proceeds as a signed-magnitude add.
- States:
  - IDLE: on input transfer, latch a and b → ALIGN.
  - ALIGN:
    - Special cases → PACK directly:
      - either operand NaN → canonical NaN 0x7F800001, out_invalid=1;
      - +Inf − +Inf or −Inf − −Inf → same canonical NaN, out_invalid=1;
      - otherwise either operand Inf → that infinity with its effective sign.
    - Normal case: order operands by {exp, mant} magnitude and right-shift the smaller by the exponent difference in one cycle. Difference ≥ 25 gives zero; shifted-out bits are dropped. Keep the larger exponent → ADD.
  - ADD:
    - Same effective signs: 25-bit add. Otherwise larger − smaller (never negative).
    - Result sign = sign of the larger magnitude → NORM.
  - NORM, one action per cycle:
    - bit24=1: shift right 1, exp+1 → PACK.
    - mant==0: result +0 (0x00000000) → PACK.
    - bit23=1 or exp==1: → PACK; with bit23=0 at exp==1 the result packs as a denormal, exponent field 0.
    - else: shift left 1, exp−1, stay.
    - Iteration counter reaching NORM_MAX forces PACK.
  - PACK:
    - Assemble {sign, exp, mant[22:0]} with truncation rounding.
    - exp ≥ 255 → {sign, 0xFF, 0}, out_overflow=1.
    - Register diff, set out_valid=1 → DONE.
  - DONE: on output transfer clear out_valid and the flags → IDLE.
- Latency, counted from the accepting edge to the edge asserting out_valid:
  - Normal, no left shift: 4 cycles.
  - +1 cycle per left-normalise shift.
  - Special case: 2 cycles.
- Throughput: one operation in flight. A new input cannot be accepted in the same cycle as the output transfer; it is accepted at the earliest in the following IDLE cycle.
- out_ready asserted early, before out_valid, has no effect.

Test Plan:
- Reset, then a=0x40400000 (3.0), b=0x3F800000 (1.0), out_ready=1 → diff=0x40000000, flags 0, out_valid exactly 4 cycles after accept, in_ready=0 throughout.
- a=0x3F800000, b=0x3F400000 (1.0−0.75) → diff=0x3E800000 after 2 normalise shifts, latency 6.
- a=b=0x3F800000 → diff=0x00000000; a=0x7F800000, b=0x7F800000 → diff=0x7F800001, out_invalid=1, latency 2.
- a=0x7F7FFFFF, b=0xFF7FFFFF → diff=0x7F800000, out_overflow=1; a=0x00000001, b=0x80000001 → diff=0x00000002 (denormal path).
- Backpressure: out_ready=0 for 5 cycles after out_valid → diff and flags stable, in_ready=0, and in_valid is ignored; raising out_ready gives one transfer, then in_ready=1 the next cycle.
- Assert rst during NORM of the 1.0−0.75 case → next cycle out_valid=0, in_ready=1, busy=0; a fresh 3.0−1.0 then completes correctly.
